// File: rtl/sll_iterative.sv
// ---------------------------------------------------------------------------
// sll_iterative
//
// Multi-cycle logical left shifter for the ALU SLL/SLLV path. The operand is
// shifted left one bit per clock with zero fill into bit 0. A start/done
// handshake is used, and the control sequencer stalls while busy is high.
// The lost output flags any 1 bit that was shifted out past the MSB.
//
// Optional feature:
//   SLL_FAST_EN  When this is defined, the SHIFT state advances by 4 bits in
//                one cycle if at least 4 bit positions remain. Results, lost
//                and the handshake are identical in both builds. Only the
//                latency differs.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous, active-high reset
//   start   in   request; sampled only when not busy (IDLE or DONE)
//   a_i     in   [WIDTH-1:0] operand, captured on the accepting edge
//   shamt   in   [SHW-1:0]   shift amount 0..WIDTH-1, captured with a_i
//   busy    out  high from the accepting edge until done is asserted
//   done    out  one-cycle pulse; result/lost are valid during it
//   result  out  [WIDTH-1:0] shifted value, held until the next op completes
//   lost    out  set if any 1 bit was shifted out; held with result
// ---------------------------------------------------------------------------
module sll_iterative #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_i,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             lost
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   cnt_nxt;
  logic             lost_acc;
  logic             lost_acc_nxt;
  logic             load_result;

`ifdef SLL_FAST_EN
  localparam logic [SHW-1:0] STEP4 = SHW'(4);
`endif

  // -------------------------------------------------------------------------
  // State register. busy and done are registered from the next state, so
  // each one matches the state it belongs to without any output decode.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments. Every flop
  // then samples the values that existed before the edge, whatever order
  // the statements are written in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      lost_acc <= 1'b0;
      result   <= '0;
      lost     <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt == SHIFT);
      done     <= (state_nxt == DONE);
      acc      <= acc_nxt;
      cnt      <= cnt_nxt;
      lost_acc <= lost_acc_nxt;
      if (load_result) begin
        result <= acc;
        lost   <= lost_acc;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. A start in DONE is accepted just as it is in IDLE.
  // This allows back-to-back operation. A start during SHIFT is dropped.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath / output logic.
  // -------------------------------------------------------------------------
  // NOTE: every signal is assigned a default before the case statement. A
  // path that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    acc_nxt      = acc;
    cnt_nxt      = cnt;
    lost_acc_nxt = lost_acc;
    load_result  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          acc_nxt      = a_i;
          cnt_nxt      = shamt;
          lost_acc_nxt = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          load_result = 1'b1;
`ifdef SLL_FAST_EN
        end else if (cnt >= STEP4) begin
          acc_nxt      = {acc[WIDTH-5:0], 4'b0000};
          cnt_nxt      = cnt - STEP4;
          lost_acc_nxt = lost_acc | (|acc[WIDTH-1:WIDTH-4]);
`endif
        end else begin
          acc_nxt      = {acc[WIDTH-2:0], 1'b0};
          cnt_nxt      = cnt - 1'b1;
          lost_acc_nxt = lost_acc | acc[WIDTH-1];
        end
      end
      default: ;
    endcase
  end

endmodule
